uart_rx_ctrl: RTL and testbench

Receive-side controller of the 16750-style UART. Captures each finished character from the receiver, including its PE/FE/BI status, and writes it into the 16-deep RX FIFO as an 11-bit word. It also generates overrun, the FIFO-error summary, the data-available trigger and the character-timeout indication. It sits between the receiver, the RX FIFO and the register/interrupt logic.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_timeout.sv | 46 ++++
 rtl/uart_rx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and decode helpers for the 16750-style UART receive path.
package uart_pkg;

  localparam int WORD_W = 11;
  localparam int BIT_BI = 10;
  localparam int BIT_FE = 9;
  localparam int BIT_PE = 8;

  function automatic logic [4:0] trig_level(input logic fifo_en, input logic [1:0] sel);
    logic [4:0] lvl;
    lvl = 5'd1;
    if (fifo_en) begin
      case (sel)
        2'b01:   lvl = 5'd4;
        2'b10:   lvl = 5'd8;
        2'b11:   lvl = 5'd14;
        default: lvl = 5'd1;
      endcase
    end
    return lvl;
  endfunction

  // start + data + optional parity + stop bits, 7..12
  function automatic logic [3:0] char_bits(input logic [1:0] wls, input logic stb,
                                           input logic pen);
    return 4'd6 + {2'b00, wls} + {3'b000, pen} + (stb ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: counts 16x baud ticks while the RX FIFO holds data
// and nothing moves, and flags CTI once TO_CHARS character times have passed.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int TO_CHARS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_rxclk,
  input  logic [1:0] i_wls,
  input  logic       i_stb,
  input  logic       i_pen,
  output logic       o_cti
);

  logic [9:0] r_tocnt;
  logic       r_cti;
  logic [9:0] w_limit;
  logic       w_restart;

  // Limit follows the live line configuration, so a running count is judged
  // against whatever format is selected right now.
  assign w_limit   = 10'(TO_CHARS * 16 * int'(char_bits(i_wls, i_stb, i_pen)));
  assign w_restart = i_clear | ~i_enable;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tocnt <= '0;
      r_cti   <= 1'b0;
    end else if (w_restart) begin
      r_tocnt <= '0;
      r_cti   <= 1'b0;
    end else begin
      if (i_rxclk && (r_tocnt < w_limit))
        r_tocnt <= r_tocnt + 10'd1;
      if (r_tocnt >= w_limit)
        r_cti <= 1'b1;
    end
  end

  assign o_cti = r_cti;

endmodule

// File: rtl/uart_rx_ctrl.sv
// RX-side controller: captures finished characters into the RX FIFO and
// derives overrun, FIFO error summary, data-available trigger and timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TO_CHARS   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RXCLK,
  input  logic [1:0]                   WLS,
  input  logic                         STB,
  input  logic                         PEN,
  input  logic                         FIFO_EN,
  input  logic [1:0]                   FCR_TRIG,
  input  logic                         FCR_RXRST,
  input  logic                         RXFINISHED,
  input  logic [7:0]                   DOUT,
  input  logic                         PE,
  input  logic                         FE,
  input  logic                         BI,
  input  logic [$clog2(FIFO_DEPTH):0]  FIFO_USAGE,
  input  logic [WORD_W-1:0]            FIFO_Q,
  input  logic                         RBR_READ,
  input  logic                         LSR_READ,
  output logic                         FIFO_WR,
  output logic [WORD_W-1:0]            FIFO_D,
  output logic                         FIFO_RD,
  output logic                         FIFO_CLR,
  output logic                         OE,
  output logic                         FIFO_ERR,
  output logic                         RDA,
  output logic                         CTI
);

  logic              r_fifo_en_d;
  logic              r_fifo_wr;
  logic              r_fifo_clr;
  logic              r_oe;
  logic              r_rda;
  logic [WORD_W-1:0] r_fifo_d;
  logic [4:0]        r_errcnt;

  logic w_clear;
  logic w_usage_nz;
  logic w_full;
  logic w_accept;
  logic w_inc;
  logic w_dec;
  logic w_to_clear;
  logic w_unused;

  assign w_clear    = FCR_RXRST | (FIFO_EN ^ r_fifo_en_d);
  assign w_usage_nz = (FIFO_USAGE != '0);
  // Non-FIFO mode behaves as a single holding register.
  assign w_full     = FIFO_EN ? (int'(FIFO_USAGE) == FIFO_DEPTH) : w_usage_nz;
  assign w_accept   = RXFINISHED & ~w_clear;

  assign FIFO_RD    = RBR_READ & w_usage_nz;
  assign w_inc      = r_fifo_wr & (|r_fifo_d[BIT_BI:BIT_PE]);
  assign w_dec      = FIFO_RD & (|FIFO_Q[BIT_BI:BIT_PE]);
  assign w_unused   = ^FIFO_Q[BIT_PE-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fifo_en_d <= 1'b0;
      r_fifo_wr   <= 1'b0;
      r_fifo_clr  <= 1'b0;
      r_oe        <= 1'b0;
      r_rda       <= 1'b0;
      r_fifo_d    <= '0;
      r_errcnt    <= '0;
    end else begin
      r_fifo_en_d <= FIFO_EN;
      r_fifo_clr  <= w_clear;
      r_fifo_wr   <= w_accept & ~w_full;
      r_rda       <= int'(FIFO_USAGE) >= int'(trig_level(FIFO_EN, FCR_TRIG));
      if (w_accept)
        r_fifo_d <= {BI, FE, PE, DOUT};
      // A fresh overrun wins over a simultaneous LSR read.
      if (w_accept & w_full)
        r_oe <= 1'b1;
      else if (LSR_READ)
        r_oe <= 1'b0;
      if (w_clear)
        r_errcnt <= '0;
      else if (w_inc && !w_dec && (r_errcnt != 5'(FIFO_DEPTH)))
        r_errcnt <= r_errcnt + 5'd1;
      else if (w_dec && !w_inc && (r_errcnt != 5'd0))
        r_errcnt <= r_errcnt - 5'd1;
    end
  end

  assign w_to_clear = w_clear | r_fifo_wr | FIFO_RD;

  uart_rx_timeout #(
    .TO_CHARS (TO_CHARS)
  ) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (w_to_clear),
    .i_enable (w_usage_nz),
    .i_rxclk  (RXCLK),
    .i_wls    (WLS),
    .i_stb    (STB),
    .i_pen    (PEN),
    .o_cti    (CTI)
  );

  assign FIFO_WR  = r_fifo_wr;
  assign FIFO_D   = r_fifo_d;
  assign FIFO_CLR = r_fifo_clr;
  assign OE       = r_oe;
  assign FIFO_ERR = (r_errcnt != 5'd0);
  assign RDA      = r_rda;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an emulated RX FIFO plus an event-level model of the
// controller, compared on every falling edge, with directed literal checks.
module tb_uart_rx_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RXCLK = 1'b0;
  logic [1:0]  WLS = 2'b11;
  logic        STB = 1'b0;
  logic        PEN = 1'b0;
  logic        FIFO_EN = 1'b1;
  logic [1:0]  FCR_TRIG = 2'b00;
  logic        FCR_RXRST = 1'b0;
  logic        RXFINISHED = 1'b0;
  logic [7:0]  DOUT = 8'h00;
  logic        PE = 1'b0;
  logic        FE = 1'b0;
  logic        BI = 1'b0;
  logic [4:0]  FIFO_USAGE = 5'd0;
  logic [10:0] FIFO_Q = 11'h000;
  logic        RBR_READ = 1'b0;
  logic        LSR_READ = 1'b0;
  logic        FIFO_WR, FIFO_RD, FIFO_CLR, OE, FIFO_ERR, RDA, CTI;
  logic [10:0] FIFO_D;

  uart_rx_ctrl #(.FIFO_DEPTH(16), .TO_CHARS(4)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .WLS(WLS), .STB(STB), .PEN(PEN),
    .FIFO_EN(FIFO_EN), .FCR_TRIG(FCR_TRIG), .FCR_RXRST(FCR_RXRST),
    .RXFINISHED(RXFINISHED), .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .FIFO_USAGE(FIFO_USAGE), .FIFO_Q(FIFO_Q), .RBR_READ(RBR_READ),
    .LSR_READ(LSR_READ), .FIFO_WR(FIFO_WR), .FIFO_D(FIFO_D), .FIFO_RD(FIFO_RD),
    .FIFO_CLR(FIFO_CLR), .OE(OE), .FIFO_ERR(FIFO_ERR), .RDA(RDA), .CTI(CTI)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // model state: what the outputs must be in the current cycle
  bit          m_wr, m_clr, m_oe, m_rda, m_cti, m_prev_en;
  logic [10:0] m_d;
  int          m_errcnt, m_tocnt;
  logic [10:0] q[$];
  bit          rxclk_always = 1'b0;
  int          trig_tab[4] = '{1, 4, 8, 14};

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare + model advance, once per cycle on the falling edge
  always @(negedge CLK) begin
    bit e_rd, clr, full, acc, toclr, inc, dec;
    int lim, trig;
    e_rd = RBR_READ && (FIFO_USAGE != 5'd0);
    if (RST) begin
      m_wr = 0; m_clr = 0; m_oe = 0; m_rda = 0; m_cti = 0; m_prev_en = 0;
      m_d = '0; m_errcnt = 0; m_tocnt = 0;
    end
    chkb("FIFO_WR", FIFO_WR, m_wr);
    chkw("FIFO_D", FIFO_D, m_d);
    chkb("FIFO_RD", FIFO_RD, e_rd);
    chkb("FIFO_CLR", FIFO_CLR, m_clr);
    chkb("OE", OE, m_oe);
    chkb("FIFO_ERR", FIFO_ERR, m_errcnt != 0);
    chkb("RDA", RDA, m_rda);
    chkb("CTI", CTI, m_cti);
    if (!RST) begin
      clr   = FCR_RXRST || (FIFO_EN != m_prev_en);
      full  = FIFO_EN ? (FIFO_USAGE == 5'd16) : (FIFO_USAGE != 5'd0);
      acc   = RXFINISHED && !clr;
      lim   = 4 * 16 * (1 + 5 + int'(WLS) + int'(PEN) + (STB ? 2 : 1));
      toclr = clr || m_wr || e_rd || (FIFO_USAGE == 5'd0);
      trig  = FIFO_EN ? trig_tab[FCR_TRIG] : 1;
      // emulated FIFO reacts to this cycle's strobes
      if (m_clr) q.delete();
      else begin
        if (e_rd && q.size() != 0) void'(q.pop_front());
        if (m_wr && q.size() < 16) q.push_back(m_d);
      end
      inc = m_wr && (m_d[10:8] != 3'b000);
      dec = e_rd && (FIFO_Q[10:8] != 3'b000);
      if (clr) m_errcnt = 0;
      else if (inc && !dec && m_errcnt < 16) m_errcnt++;
      else if (dec && !inc && m_errcnt > 0) m_errcnt--;
      m_cti   = toclr ? 1'b0 : (m_cti || m_tocnt >= lim);
      m_tocnt = toclr ? 0 : ((RXCLK && m_tocnt < lim) ? m_tocnt + 1 : m_tocnt);
      if (acc && full) m_oe = 1;
      else if (LSR_READ) m_oe = 0;
      if (acc) m_d = {BI, FE, PE, DOUT};
      m_wr      = acc && !full;
      m_clr     = clr;
      m_rda     = int'(FIFO_USAGE) >= trig;
      m_prev_en = FIFO_EN;
    end
  end

  task automatic apply_fifo();
    FIFO_USAGE = 5'(q.size());
    FIFO_Q     = (q.size() != 0) ? q[0] : 11'h000;
  endtask

  task automatic set_fifo(input int n, input logic [10:0] w);
    q.delete();
    repeat (n) q.push_back(w);
    apply_fifo();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    RXFINISHED = 0; RBR_READ = 0; LSR_READ = 0; FCR_RXRST = 0;
    RXCLK = rxclk_always ? 1'b1 : ($urandom_range(0, 3) == 0);
    apply_fifo();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chkb("reset OE", OE, 1'b0);
    chkb("reset FIFO_WR", FIFO_WR, 1'b0);
    RST = 0;
    repeat (4) step();

    // normal push
    set_fifo(0, 11'h0);
    DOUT = 8'h5A; RXFINISHED = 1;
    step();
    chkb("push WR", FIFO_WR, 1'b1);
    chkw("push D", FIFO_D, 11'h05A);
    chkb("push OE", OE, 1'b0);
    step();
    chkb("push ERR", FIFO_ERR, 1'b0);

    // overrun in FIFO mode, then LSR read
    set_fifo(16, 11'h0);
    RXFINISHED = 1;
    step();
    chkb("ovr WR", FIFO_WR, 1'b0);
    chkb("ovr OE", OE, 1'b1);
    LSR_READ = 1;
    step();
    chkb("lsr OE", OE, 1'b0);

    // overrun in holding-register mode
    FIFO_EN = 0;
    repeat (3) step();
    set_fifo(1, 11'h0);
    RXFINISHED = 1;
    step();
    chkb("nf WR", FIFO_WR, 1'b0);
    chkb("nf OE", OE, 1'b1);
    step();
    chkb("nf RDA", RDA, 1'b1);
    LSR_READ = 1;
    step();
    FIFO_EN = 1;
    repeat (3) step();

    // error tracking
    set_fifo(0, 11'h0);
    DOUT = 8'h00; BI = 1; FE = 1; RXFINISHED = 1;
    step();
    chkw("err D", FIFO_D, 11'h600);
    BI = 0; FE = 0;
    step();
    chkb("err set", FIFO_ERR, 1'b1);
    RBR_READ = 1;
    step();
    chkb("err clr", FIFO_ERR, 1'b0);

    // character timeout, LIMIT = 640
    rxclk_always = 1; WLS = 2'b11; PEN = 0; STB = 0;
    set_fifo(0, 11'h0);
    repeat (3) step();
    set_fifo(2, 11'h0);
    repeat (640) step();
    chkb("cti early", CTI, 1'b0);
    step();
    chkb("cti set", CTI, 1'b1);
    RBR_READ = 1;
    step();
    chkb("cti rd clr", CTI, 1'b0);
    set_fifo(0, 11'h0);
    repeat (700) step();
    chkb("cti empty", CTI, 1'b0);
    rxclk_always = 0;

    // trigger level 8
    FCR_TRIG = 2'b10;
    set_fifo(7, 11'h0);
    step();
    chkb("rda 7", RDA, 1'b0);
    set_fifo(8, 11'h0);
    step();
    chkb("rda 8", RDA, 1'b1);

    // software clear keeps OE
    set_fifo(0, 11'h0);
    PE = 1; RXFINISHED = 1;
    step();
    PE = 0;
    step();
    chkb("clr pre ERR", FIFO_ERR, 1'b1);
    set_fifo(16, 11'h0);
    RXFINISHED = 1;
    step();
    chkb("clr pre OE", OE, 1'b1);
    FCR_RXRST = 1;
    step();
    chkb("clr pulse", FIFO_CLR, 1'b1);
    chkb("clr ERR", FIFO_ERR, 1'b0);
    chkb("clr OE", OE, 1'b1);
    step();
    chkb("clr once", FIFO_CLR, 1'b0);
    LSR_READ = 1;
    step();

    // randomized traffic; second half favours long idle periods
    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      quiet = (i >= 2000);
      rxclk_always = quiet;
      if ($urandom_range(0, quiet ? 249 : 19) == 0) begin
        RXFINISHED = 1;
        DOUT = 8'($urandom);
        {BI, FE, PE} = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      if ($urandom_range(0, quiet ? 299 : 5) == 0) RBR_READ = 1;
      if ($urandom_range(0, 9) == 0) LSR_READ = 1;
      if ($urandom_range(0, 299) == 0) FCR_RXRST = 1;
      if ($urandom_range(0, 399) == 0) FIFO_EN = ~FIFO_EN;
      if ($urandom_range(0, 49) == 0) FCR_TRIG = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        WLS = 2'($urandom_range(0, 3));
        STB = 1'($urandom_range(0, 1));
        PEN = 1'($urandom_range(0, 1));
      end
      step();
    end
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
